// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// The divider datapath is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    // RV32M funct3 encoding
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    // Control FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: used both to take operand magnitudes
// and to restore the sign of products, quotients and remainders.
module muldiv_negate #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_val,
    input  logic         i_neg,
    output logic [N-1:0] o_val
);

    // Negate when requested, pass through otherwise
    always_comb o_val = i_neg ? ('0 - i_val) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per CALC cycle.
// Define MULDIV_DIV_EN to build the divider; otherwise divide/remainder
// ops complete immediately with result 0.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         busy
);

    localparam int CW = $clog2(N) + 1;

    muldiv_state_t r_state;
    muldiv_op_t    r_op;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_busy;
    logic [N-1:0]  r_result;
    logic [CW-1:0] r_cnt;
    // r_hi: product high half / partial remainder
    // r_lo: multiplier shifting out, or dividend shifting out / quotient shifting in
    // r_opnd: multiplicand or divisor magnitude
    logic [N-1:0]  r_hi;
    logic [N-1:0]  r_lo;
    logic [N-1:0]  r_opnd;
    logic          r_neg_p;

    muldiv_op_t    w_op;
    logic          w_a_neg;
    logic          w_b_neg;
    logic [N-1:0]  w_a_mag;
    logic [N-1:0]  w_b_mag;
    logic [N-1:0]  w_addend;
    logic [N:0]    w_sum;
    logic [N-1:0]  w_next_hi;
    logic [N-1:0]  w_next_lo;
    logic [2*N-1:0] w_prod_fix;
    logic [N-1:0]  w_final;
    logic          w_last;

`ifdef MULDIV_DIV_EN
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
    logic          r_neg_r;
    logic [N:0]    w_shift;
    logic [N-1:0]  w_diff;
    logic [N-1:0]  w_quot_fix;
    logic [N-1:0]  w_rem_fix;
`endif

    assign w_op    = muldiv_op_t'(op);
    assign w_a_neg = a[N-1] & ((w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                               (w_op == OP_DIV)  || (w_op == OP_REM));
    assign w_b_neg = b[N-1] & ((w_op == OP_MULH) || (w_op == OP_DIV) ||
                               (w_op == OP_REM));
    assign w_last  = (r_cnt == CW'(N - 1));

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;

    muldiv_negate #(.N(N)) u_neg_a (
        .i_val (a),
        .i_neg (w_a_neg),
        .o_val (w_a_mag)
    );

    muldiv_negate #(.N(N)) u_neg_b (
        .i_val (b),
        .i_neg (w_b_neg),
        .o_val (w_b_mag)
    );

    muldiv_negate #(.N(2 * N)) u_neg_prod (
        .i_val ({w_next_hi, w_next_lo}),
        .i_neg (r_neg_p),
        .o_val (w_prod_fix)
    );

`ifdef MULDIV_DIV_EN
    muldiv_negate #(.N(N)) u_neg_quot (
        .i_val (w_next_lo),
        .i_neg (r_neg_p),
        .o_val (w_quot_fix)
    );

    muldiv_negate #(.N(N)) u_neg_rem (
        .i_val (w_next_hi),
        .i_neg (r_neg_r),
        .o_val (w_rem_fix)
    );
`endif

    // One iteration step of the active algorithm
    always_comb begin
        w_addend  = r_lo[0] ? r_opnd : '0;
        w_sum     = '0;
        w_next_hi = r_hi;
        w_next_lo = r_lo;
`ifdef MULDIV_DIV_EN
        w_shift   = {r_hi, r_lo[N-1]};
        w_diff    = w_shift[N-1:0] - r_opnd;
`endif
        if (!r_op[2]) begin
            w_sum     = {1'b0, r_hi} + {1'b0, w_addend};
            w_next_hi = w_sum[N:1];
            w_next_lo = {w_sum[0], r_lo[N-1:1]};
        end
`ifdef MULDIV_DIV_EN
        else if (w_shift >= {1'b0, r_opnd}) begin
            w_next_hi = w_diff;
            w_next_lo = {r_lo[N-2:0], 1'b1};
        end else begin
            w_next_hi = w_shift[N-1:0];
            w_next_lo = {r_lo[N-2:0], 1'b0};
        end
`endif
    end

    // Select and sign-correct the value written into result after the last step
    always_comb begin
        w_final = (r_op == OP_MUL) ? w_prod_fix[N-1:0] : w_prod_fix[2*N-1:N];
`ifdef MULDIV_DIV_EN
        if (r_op[2]) begin
            w_final = r_op[1] ? w_rem_fix : w_quot_fix;
        end
`endif
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_MUL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opnd      <= '0;
            r_neg_p     <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_neg_r     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op       <= w_op;
                        r_neg_p    <= w_a_neg ^ w_b_neg;
                        r_cnt      <= '0;
                        r_hi       <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (!op[2]) begin
                            r_opnd  <= w_a_mag;
                            r_lo    <= w_b_mag;
                            r_state <= S_CALC;
                        end else begin
`ifdef MULDIV_DIV_EN
                            r_opnd  <= w_b_mag;
                            r_lo    <= w_a_mag;
                            r_neg_r <= w_a_neg;
                            if (b == '0) begin
                                r_result    <= op[1] ? a : '1;
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end else if (!op[0] && (a == MOST_NEG) && (b == '1)) begin
                                r_result    <= op[1] ? '0 : a;
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_state <= S_CALC;
                            end
`else
                            r_result    <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
`endif
                        end
                    end
                end
                S_CALC: begin
                    r_hi  <= w_next_hi;
                    r_lo  <= w_next_lo;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_result    <= w_final;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (N=32): directed and random requests,
// reference results from plain 64-bit arithmetic, latency and hold checks.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] want;
    } chk_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        busy;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   ready_mode = 1;   // 0 low, 1 high, 2 random
    bit   seen = 1'b0;
    exp_t exp_q[$];
    chk_t chk_q[$];
    exp_t e;
    chk_t c;

    muldiv_unit #(.N(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (ready_mode == 0)      out_ready = 1'b0;
        else if (ready_mode == 1) out_ready = 1'b1;
        else                      out_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        longint sx;
        longint sy;
        logic [63:0] p;
`ifdef MULDIV_DIV_EN
        int sa;
        int sb;
`endif
        sx = (o == 3'd1 || o == 3'd2) ? longint'($signed(x)) : longint'({32'h0, x});
        sy = (o == 3'd1) ? longint'($signed(y)) : longint'({32'h0, y});
        p  = 64'(sx * sy);
        if (o == 3'd0) return p[31:0];
        if (o < 3'd4)  return p[63:32];
`ifdef MULDIV_DIV_EN
        if (y == 32'h0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : x;
            sa = $signed(x);
            sb = $signed(y);
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? (x % y) : (x / y);
`else
        return 32'h0;
`endif
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
        if (!o[2]) return 33;
`ifdef MULDIV_DIV_EN
        if (y == 32'h0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
`else
        return 1;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string n, input logic [31:0] g, input logic [31:0] w);
        chk_q.push_back('{n, g, w});
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push);
        int w = 0;
        bit ok = 1'b0;
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        while (!ok && w < 500) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            w++;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        else if (push) exp_q.push_back('{ref_res(o, x, y), cyc, ref_lat(o, x, y)});
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares queued direct checks and every presented result
    always @(negedge clk) begin
        while (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            n_cmp++;
            if (c.got !== c.want) begin
                n_err++;
                $display("FAIL %s: got %h want %h", c.name, c.got, c.want);
            end
        end
        if (reset) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got %h want none", result);
            end else begin
                e = exp_q[0];
                if (!seen) begin
                    n_cmp++;
                    if (cyc - e.acc != e.lat) begin
                        n_err++;
                        $display("FAIL latency: got %0d want %0d", cyc - e.acc, e.lat);
                    end
                    seen = 1'b1;
                end
                n_cmp++;
                if (result !== e.res) begin
                    n_err++;
                    $display("FAIL result: got %h want %h", result, e.res);
                end
                n_cmp++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL done_flags: got in_ready=%b busy=%b want 0 1", in_ready, busy);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);

        // Directed corner cases
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(3'd5, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(3'd5, 32'd5, 32'd0, 1'b1);
        issue(3'd7, 32'd5, 32'd0, 1'b1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(3'd4, 32'd10, 32'd3, 1'b1);
        issue(3'd0, 32'd6, 32'd7, 1'b1);
        drain();

        // Result held while consumer stalls
        ready_mode = 0;
        issue(3'd1, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("hold_reached", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        ready_mode = 1;
        drain();

        // Reset during CALC aborts with no result
        issue(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", result, 32'd0);
        repeat (40) @(negedge clk);

        // Random traffic with random back-pressure
        ready_mode = 2;
        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom), pick(), pick(), 1'b1);
        end
        drain();
        ready_mode = 1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
